// File: rtl/int_to_fp_seq.sv
// int_to_fp_seq: multi-cycle signed 32-bit integer to IEEE-754 single-precision
// converter. An iterative normaliser shifts the magnitude left (coarse steps of
// COARSE_SHIFT bits while the top bits are clear, otherwise single steps), then
// one rounding cycle applies round-to-nearest-even.
//
// Optional build macro: INT_TO_FP_INEXACT_EN adds the out_inexact port, which
// flags that the result was rounded (guard | sticky).
//
//   state | meaning
//   IDLE  | waiting for a request, in_ready high
//   NORM  | shifting mag left until bit 31 is set, tracking exp
//   ROUND | round-to-nearest-even on the normalised mantissa, build result
//   DONE  | holding out_valid/out_data until the consumer takes them

module int_to_fp_seq #(
    parameter int COARSE_SHIFT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
`ifdef INT_TO_FP_INEXACT_EN
    ,
    output logic        out_inexact
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    // Exponent of an operand whose leading one already sits in bit 31.
    localparam logic [7:0] EXP_TOP    = 8'd158;
    localparam logic [7:0] COARSE_EXP = 8'(COARSE_SHIFT);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] mag;
    logic [7:0]  exp;
    logic        sign;

    logic        accept;
    logic [31:0] in_abs;
    logic        coarse_zero;
    logic [22:0] frac0;
    logic        guard;
    logic        sticky;
    logic        inc;
    logic [23:0] frac_sum;
    logic        carry;
    logic [22:0] frac_rnd;
    logic [7:0]  exp_rnd;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign in_abs      = in_data[31] ? (~in_data + 32'd1) : in_data;
    assign coarse_zero = (mag[31 -: COARSE_SHIFT] == '0);

    // Round-to-nearest-even on the normalised magnitude; a carry out of the
    // fraction means the mantissa overflowed to 2.0, so bump the exponent.
    assign frac0    = mag[30:8];
    assign guard    = mag[7];
    assign sticky   = |mag[6:0];
    assign inc      = guard && (sticky || frac0[0]);
    assign frac_sum = {1'b0, frac0} + {23'd0, inc};
    assign carry    = frac_sum[23];
    assign frac_rnd = frac_sum[22:0];
    assign exp_rnd  = exp + {7'd0, carry};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (in_data == 32'd0) ? DONE : NORM;
                end
            end
            NORM: begin
                if (mag[31]) begin
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, normalisation shifts, result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag       <= '0;
            exp       <= '0;
            sign      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef INT_TO_FP_INEXACT_EN
            out_inexact <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign <= in_data[31];
                        mag  <= in_abs;
                        exp  <= EXP_TOP;
                        // Zero skips normalisation; always +0, never -0.
                        if (in_data == 32'd0) begin
                            out_data  <= '0;
                            out_valid <= 1'b1;
`ifdef INT_TO_FP_INEXACT_EN
                            out_inexact <= 1'b0;
`endif
                        end
                    end
                end
                NORM: begin
                    if (!mag[31]) begin
                        if (coarse_zero) begin
                            mag <= mag << COARSE_SHIFT;
                            exp <= exp - COARSE_EXP;
                        end else begin
                            mag <= mag << 1;
                            exp <= exp - 8'd1;
                        end
                    end
                end
                ROUND: begin
                    out_data  <= {sign, exp_rnd, frac_rnd};
                    out_valid <= 1'b1;
`ifdef INT_TO_FP_INEXACT_EN
                    out_inexact <= guard | sticky;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
